csi_packet_parser: RTL

- Consumes the sync-aligned byte stream of one CSI-2 lane after the SoT sync byte has been stripped.
- Assembles the 4-byte packet header and passes it to the downstream ECC block (instanced alongside, combinational).
- Uses the corrected header to classify each packet as short or long, and for long packets streams WC payload bytes followed by the 2-byte CRC.
- Sits between the lane byte aligner and the pixel/CRC-check stages.

---
 rtl/csi_packet_parser.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/csi_packet_parser.sv
// CSI-2 single-lane packet parser: gathers the 4-byte packet header for an external
// ECC block, classifies the corrected header and streams long-packet payload and CRC.
module csi_packet_parser #(
  parameter int          PH_SIZE   = 32,
  parameter int          ECC_SIZE  = 8,
  parameter int          DATA_SIZE = PH_SIZE - ECC_SIZE,
  parameter logic [15:0] MAX_WC    = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  input  logic                 sot,
  input  logic                 eot,
  output logic [PH_SIZE-1:0]   PH_in,
  input  logic [DATA_SIZE-1:0] PH_out,
  input  logic                 no_error,
  input  logic                 corrected_error,
  input  logic                 error,
  output logic                 header_valid,
  output logic [5:0]           data_type,
  output logic [1:0]           virtual_channel,
  output logic [15:0]          word_count,
  output logic                 short_packet,
  output logic                 ecc_corrected,
  output logic                 header_error,
  output logic [7:0]           payload_data,
  output logic                 payload_valid,
  output logic                 payload_last,
  output logic [15:0]          crc_rx,
  output logic                 packet_done,
  output logic                 truncated
);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, WAIT_EOT} state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [DATA_SIZE-1:0] hdr_q, hdr_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 header_valid_q, header_valid_d;
  logic [5:0]           data_type_q, data_type_d;
  logic [1:0]           vc_q, vc_d;
  logic [15:0]          wc_q, wc_d;
  logic                 short_q, short_d;
  logic                 ecc_corr_q, ecc_corr_d;
  logic                 header_error_q, header_error_d;
  logic [7:0]           pay_data_q, pay_data_d;
  logic                 pay_valid_q, pay_valid_d;
  logic                 pay_last_q, pay_last_d;
  logic [15:0]          crc_q, crc_d;
  logic                 done_q, done_d;
  logic                 trunc_q, trunc_d;

  logic [15:0] ph_wc;
  logic        ph_short;
  logic        hdr_bad;

  // The ECC block sees the 4th byte straight from the lane so its status is ready in the same cycle.
  assign PH_in    = (state_q == HDR && idx_q == 2'd3) ? {byte_in, hdr_q} : {8'h00, hdr_q};
  assign ph_wc    = PH_out[23:8];
  assign ph_short = PH_out[5:0] < 6'h10;
  // A status word with neither "clean" nor "corrected" set is treated as uncorrectable.
  assign hdr_bad  = error | ~(no_error | corrected_error) | ({1'b0, ph_wc} > {1'b0, MAX_WC});

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    hdr_d          = hdr_q;
    cnt_d          = cnt_q;
    data_type_d    = data_type_q;
    vc_d           = vc_q;
    wc_d           = wc_q;
    short_d        = short_q;
    ecc_corr_d     = ecc_corr_q;
    pay_data_d     = pay_data_q;
    crc_d          = crc_q;
    header_valid_d = 1'b0;
    header_error_d = 1'b0;
    pay_valid_d    = 1'b0;
    pay_last_d     = 1'b0;
    done_d         = 1'b0;
    trunc_d        = 1'b0;

    if (eot) begin
      trunc_d = (state_q == HDR) || (state_q == PAYLOAD) || (state_q == CRC);
      state_d = IDLE;
      idx_d   = 2'd0;
    end else if (sot) begin
      trunc_d = (state_q == HDR && idx_q != 2'd0) || (state_q == PAYLOAD) || (state_q == CRC);
      state_d = HDR;
      idx_d   = 2'd0;
    end else if (byte_valid) begin
      case (state_q)
        HDR: begin
          case (idx_q)
            2'd0:    hdr_d[7:0]   = byte_in;
            2'd1:    hdr_d[15:8]  = byte_in;
            2'd2:    hdr_d[23:16] = byte_in;
            default: ;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (hdr_bad) begin
              header_error_d = 1'b1;
              state_d        = WAIT_EOT;
            end else begin
              header_valid_d = 1'b1;
              data_type_d    = PH_out[5:0];
              vc_d           = PH_out[7:6];
              wc_d           = ph_wc;
              short_d        = ph_short;
              ecc_corr_d     = corrected_error;
              if (ph_short) begin
                done_d  = 1'b1;
                state_d = WAIT_EOT;
              end else if (ph_wc == 16'd0) begin
                state_d = CRC;
              end else begin
                cnt_d   = ph_wc;
                state_d = PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          pay_data_d  = byte_in;
          pay_valid_d = 1'b1;
          cnt_d       = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            pay_last_d = 1'b1;
            state_d    = CRC;
          end
        end
        CRC: begin
          if (idx_q == 2'd0) begin
            crc_d[7:0] = byte_in;
            idx_d      = 2'd1;
          end else begin
            crc_d[15:8] = byte_in;
            idx_d       = 2'd0;
            done_d      = 1'b1;
            state_d     = WAIT_EOT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      hdr_q          <= '0;
      cnt_q          <= '0;
      header_valid_q <= 1'b0;
      data_type_q    <= '0;
      vc_q           <= '0;
      wc_q           <= '0;
      short_q        <= 1'b0;
      ecc_corr_q     <= 1'b0;
      header_error_q <= 1'b0;
      pay_data_q     <= '0;
      pay_valid_q    <= 1'b0;
      pay_last_q     <= 1'b0;
      crc_q          <= '0;
      done_q         <= 1'b0;
      trunc_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      hdr_q          <= hdr_d;
      cnt_q          <= cnt_d;
      header_valid_q <= header_valid_d;
      data_type_q    <= data_type_d;
      vc_q           <= vc_d;
      wc_q           <= wc_d;
      short_q        <= short_d;
      ecc_corr_q     <= ecc_corr_d;
      header_error_q <= header_error_d;
      pay_data_q     <= pay_data_d;
      pay_valid_q    <= pay_valid_d;
      pay_last_q     <= pay_last_d;
      crc_q          <= crc_d;
      done_q         <= done_d;
      trunc_q        <= trunc_d;
    end
  end

  assign header_valid    = header_valid_q;
  assign data_type       = data_type_q;
  assign virtual_channel = vc_q;
  assign word_count      = wc_q;
  assign short_packet    = short_q;
  assign ecc_corrected   = ecc_corr_q;
  assign header_error    = header_error_q;
  assign payload_data    = pay_data_q;
  assign payload_valid   = pay_valid_q;
  assign payload_last    = pay_last_q;
  assign crc_rx          = crc_q;
  assign packet_done     = done_q;
  assign truncated       = trunc_q;

endmodule
